// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage MIPS pipeline: operand and HI/LO forwarding, load-use,
// branch and divider stalls, exception flush, and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int REG_AW      = 5,
  parameter int LONG_CYCLES = 32,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic              balD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic              divstartE,
  input  logic              hiloreadE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic              regwriteM,
  input  logic              memtoregM,
  input  logic              hilowriteM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteW,
  input  logic              hilowriteW,
  input  logic              flush_excp,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic [1:0]        forwardhE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              div_busy,
  output logic              div_done,
  output logic [CNT_W-1:0]  stall_cnt
);

  // A one-cycle divider still needs a one-bit counter to hold its (zero) load value.
  localparam int DCW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} div_state_t;

  div_state_t     state;
  logic [DCW-1:0] div_cnt;
  logic           lwstall;
  logic           branchstall;
  logic           stall_div;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // M has priority over W because it holds the younger result.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic [REG_AW-1:0] wm, input logic rwm,
                                         input logic [REG_AW-1:0] ww, input logic rww);
    if (src != '0 && src == wm && rwm)      return 2'b10;
    else if (src != '0 && src == ww && rww) return 2'b01;
    else                                    return 2'b00;
  endfunction

  always_comb begin
    lwstall     = memtoregE && (writeregE != '0) &&
                  (rsD == writeregE || rtD == writeregE);
    branchstall = branchD &&
                  ((regwriteE && (writeregE != '0) && (rsD == writeregE || rtD == writeregE)) ||
                   (memtoregM && (writeregM != '0) && (rsD == writeregM || rtD == writeregM)));
    stall_div   = (state == IDLE && divstartE) || (state == BUSY);

    forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
    forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;
    forwardaE = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
    forwardbE = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);
    forwardhE = !hiloreadE ? 2'b00 : hilowriteM ? 2'b10 : hilowriteW ? 2'b01 : 2'b00;

    stallF = lwstall || branchstall || stall_div;
    stallD = stallF;
    stallE = stall_div;
    // A held E stage must keep its instruction, so it is never bubbled while stalled.
    flushE = (lwstall || branchstall) && !balD && !stall_div;
    flushD = 1'b0;
    flushM = 1'b0;

    if (!resetn) begin
      forwardaD = 1'b0;
      forwardbD = 1'b0;
      forwardaE = 2'b00;
      forwardbE = 2'b00;
      forwardhE = 2'b00;
    end
    if (!resetn || flush_excp) begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
    end
  end

  // Divider occupancy FSM and stall counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      div_cnt   <= '0;
      div_busy  <= 1'b0;
      div_done  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (stallF) stall_cnt <= sat_inc(stall_cnt);
      if (flush_excp) begin
        state    <= IDLE;
        div_cnt  <= '0;
        div_busy <= 1'b0;
        div_done <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            div_done <= 1'b0;
            if (divstartE) begin
              state    <= BUSY;
              div_cnt  <= DCW'(LONG_CYCLES - 1);
              div_busy <= 1'b1;
            end
          end
          BUSY: begin
            if (div_cnt == '0) begin
              state    <= DONE;
              div_busy <= 1'b0;
              div_done <= 1'b1;
            end else begin
              div_cnt <= div_cnt - DCW'(1);
            end
          end
          DONE: begin
            state    <= IDLE;
            div_done <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            div_cnt  <= '0;
            div_busy <= 1'b0;
            div_done <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised next-generation hazard unit for the 5-stage MIPS pipeline.
- Keeps the existing combinational hazard functions: D/E forwarding, load-use stall, branch stall and HI/LO forwarding.
- Adds an internal multi-cycle divider occupancy FSM, so divide stalls are generated here rather than fed in as stall_divE.
- Adds an exception flush path and a saturating stall-cycle performance counter.

Parameters:
REG_AW, 5, register index width (rs/rt/writereg fields).
LONG_CYCLES, 32, busy cycles of the divider after issue; legal range >= 1.
CNT_W, 16, width of stall_cnt.

Ports:
clk  input  1  clock, rising edge
resetn  input  1  synchronous active-low reset
rsD, rtD  input  REG_AW  decode source registers
branchD  input  1  branch in D
balD  input  1  branch-and-link in D (suppresses flushE)
rsE, rtE  input  REG_AW  execute source registers
writeregE  input  REG_AW  execute destination
regwriteE, memtoregE  input  1  execute write / load
divstartE  input  1  divide instruction present in E
hiloreadE  input  1  mfhi/mflo in E
writeregM  input  REG_AW  memory destination
regwriteM, memtoregM, hilowriteM  input  1  memory-stage controls
writeregW  input  REG_AW  writeback destination
regwriteW, hilowriteW  input  1  writeback controls
flush_excp  input  1  exception flush request
forwardaD, forwardbD  output  1  D operand from M
forwardaE, forwardbE  output  2  10 = from M, 01 = from W, 00 = regfile
forwardhE  output  2  HI/LO source: 10 = M, 01 = W, 00 = HI/LO regs
stallF, stallD, stallE  output  1  stage holds
flushD, flushE, flushM  output  1  stage bubbles
div_busy  output  1  registered; FSM in BUSY
div_done  output  1  registered; one-cycle pulse in DONE
stall_cnt  output  CNT_W  registered count of stallF cycles

Behaviour:
- Forwarding, all combinational:
  - forwardaD=1 iff rsD!=0 & rsD==writeregM & regwriteM; forwardbD likewise on rtD.
  - forwardaE: M match has priority over W match; zero register is never forwarded. forwardbE likewise on rtE.
  - forwardhE=10 if hiloreadE & hilowriteM, else 01 if hiloreadE & hilowriteW, else 00.
- Stall terms:
  - lwstall = memtoregE & writeregE!=0 & (rsD==writeregE | rtD==writeregE).
  - branchstall = branchD & [ (regwriteE & writeregE!=0 & (rsD==writeregE | rtD==writeregE)) | (memtoregM & writeregM!=0 & (rsD==writeregM | rtD==writeregM)) ].
  - stall_div = (state==IDLE & divstartE) | state==BUSY.
- Divider FSM, states IDLE / BUSY / DONE, 2-bit state, counter of clog2(LONG_CYCLES) bits:
  - IDLE -> BUSY when divstartE & ~flush_excp; counter loads LONG_CYCLES-1.
  - BUSY: counter decrements each cycle; at counter==0 -> DONE.
  - DONE -> IDLE unconditionally; divstartE is ignored in DONE.
  - Any state -> IDLE on flush_excp (abort); the counter is cleared.
  - Result: a divide stalls E for exactly LONG_CYCLES+1 cycles, then advances at the end of the DONE cycle.
  - div_busy=1 in BUSY only; div_done=1 in DONE only.
- Outputs when flush_excp=0:
  - stallF = stallD = lwstall | branchstall | stall_div.
  - stallE = stall_div.
  - flushE = (lwstall | branchstall) & ~balD & ~stall_div; E is never flushed while it holds.
  - flushD = flushM = 0.
- Outputs when flush_excp=1 (dominates everything): all stalls 0; flushD = flushE = flushM = 1.
- stall_cnt:
  - Increments by 1 on each clock with stallF=1 and resetn=1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.
- Reset (resetn=0 at a clock edge):
  - state=IDLE, counter=0, div_busy=0, div_done=0, stall_cnt=0.
  - While resetn=0, combinational outputs are forced: all stalls 0, all flushes 1, all forwards 0.
  - Reset mid-divide aborts the divide with no DONE pulse.

Test Plan:
- Forward priority: rsE=5 with writeregM=5/regwriteM=1 and writeregW=5/regwriteW=1 -> forwardaE=10. Repeat with rsE=0 -> forwardaE=00.
- Load-use: memtoregE=1, writeregE=8, rtD=8 -> stallF=stallD=1, flushE=1, stall_cnt +1. Repeat with writeregE=0 -> no stall.
- Branch with link: branchD=1, balD=1, regwriteE=1, writeregE=rsD=3 -> stallF=1, flushE=0.
- Divide with LONG_CYCLES=4: divstartE=1 held -> stallE=1 for exactly 5 cycles; div_busy high 4 cycles; div_done pulses on cycle 6; stallE=0 in DONE; stall_cnt=5.
- Exception mid-divide: flush_excp on 2nd BUSY cycle -> next cycle state IDLE, div_busy=0, no div_done. During the flush: flushD=flushE=flushM=1, all stalls 0.
- Saturation with CNT_W=3: hold lwstall 10 cycles -> stall_cnt stops at 7. Then resetn=0 for one edge -> stall_cnt=0, and all flushes read 1 while resetn=0.
